// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-bus master.
// REG_BUS_WR_VERIFY_EN adds the write-verify readback states.
package reg_bus_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SEL_W_DEF  = 1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StDrive   = 3'd1;
  localparam state_t StRdWait  = 3'd2;
  localparam state_t StResp    = 3'd3;
`ifdef REG_BUS_WR_VERIFY_EN
  localparam state_t StVrdDrive = 3'd4;
  localparam state_t StVrdWait  = 3'd5;
`endif

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/reg_bus_lat_counter.sv
// Read-latency down-counter: load with LAT, count while enabled, done in the last wait cycle.
module reg_bus_lat_counter #(
  parameter int unsigned LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(LAT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(LAT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  assign done_o = en_i && (cnt_q == CntW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_bus_master.sv
// Single-outstanding initiator for the register-slave bus.
// Define REG_BUS_WR_VERIFY_EN to read back every legal write and flag mismatches.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned SEL_W    = SEL_W_DEF,
  parameter int unsigned NUM_REGS = 2,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_rw,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [15:0]       txn_cnt
);

  state_t            state_q, state_d;
  op_e               op_q, op_d;
  logic              bus_rw_q, bus_rw_d;
  logic              bus_oe_q, bus_oe_d;
  logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       txn_cnt_q, txn_cnt_d;

  logic cnt_load, cnt_en, cnt_done;
  logic cmd_legal;

  assign cmd_legal = 32'(cmd_sel) < NUM_REGS;

  reg_bus_lat_counter #(
    .LAT(RD_LAT)
  ) u_lat_counter (
    .clk_i (clk),
    .rst_i (rst),
    .load_i(cnt_load),
    .en_i  (cnt_en),
    .done_o(cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bus_rw_d    = 1'b0;
    bus_oe_d    = 1'b0;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    txn_cnt_d   = txn_cnt_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d = op_e'(cmd_write);
          if (cmd_legal) begin
            state_d   = StDrive;
            bus_sel_d = cmd_sel;
            if (cmd_write) begin
              bus_rw_d    = 1'b1;
              bus_oe_d    = 1'b1;
              bus_wdata_d = cmd_wdata;
            end
          end else begin
            // Illegal select answers immediately and never touches the bus.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      StDrive: begin
        if (op_q == OP_WRITE) begin
`ifdef REG_BUS_WR_VERIFY_EN
          state_d = StVrdDrive;
`else
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
`endif
        end else begin
          state_d  = StRdWait;
          cnt_load = 1'b1;
        end
      end

      StRdWait: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus_rdata;
        end
      end

`ifdef REG_BUS_WR_VERIFY_EN
      StVrdDrive: begin
        state_d  = StVrdWait;
        cnt_load = 1'b1;
      end

      StVrdWait: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_rdata;
          rsp_err_d   = (bus_rdata != bus_wdata_q);
        end
      end
`endif

      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          txn_cnt_d   = txn_cnt_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OP_READ;
      bus_rw_q    <= 1'b0;
      bus_oe_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bus_rw_q    <= bus_rw_d;
      bus_oe_q    <= bus_oe_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_rw    = bus_rw_q;
  assign bus_oe    = bus_oe_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench: DUT 0 (RD_LAT=1, NUM_REGS=2) with a slave model, DUT 1 (RD_LAT=3, NUM_REGS=1).
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  localparam int unsigned RdLatA = 1;
  localparam int unsigned RdLatB = 3;
  localparam logic [31:0] BRdata = 32'hC0DE_0B03;
`ifdef REG_BUS_WR_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif

  typedef struct {
    rsp_t rsp;
    int   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid [2];
  logic        cmd_write [2];
  logic [0:0]  cmd_sel   [2];
  logic [31:0] cmd_wdata [2];
  logic        rsp_ready [2];
  logic [31:0] bus_rdata [2];
  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        bus_rw    [2];
  logic [0:0]  bus_sel   [2];
  logic [31:0] bus_wdata [2];
  logic        bus_oe    [2];
  logic [15:0] txn_cnt   [2];

  logic [31:0] slave_regs [2];
  logic [31:0] shadow     [2];
  logic [15:0] exp_txn    [2];
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  reg_bus_master #(.DATA_W(32), .SEL_W(1), .NUM_REGS(2), .RD_LAT(RdLatA)) u_dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_sel(cmd_sel[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .bus_rw(bus_rw[0]), .bus_sel(bus_sel[0]), .bus_wdata(bus_wdata[0]),
    .bus_oe(bus_oe[0]), .bus_rdata(bus_rdata[0]), .txn_cnt(txn_cnt[0])
  );

  reg_bus_master #(.DATA_W(32), .SEL_W(1), .NUM_REGS(1), .RD_LAT(RdLatB)) u_dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_sel(cmd_sel[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .bus_rw(bus_rw[1]), .bus_sel(bus_sel[1]), .bus_wdata(bus_wdata[1]),
    .bus_oe(bus_oe[1]), .bus_rdata(bus_rdata[1]), .txn_cnt(txn_cnt[1])
  );

  // Slave for DUT 0: register 1 has bit 0 stuck at zero.
  always @(posedge clk) begin
    if (rst) begin
      slave_regs[0] <= '0;
      slave_regs[1] <= '0;
    end else if (bus_rw[0] && bus_oe[0]) begin
      slave_regs[bus_sel[0]] <= (bus_sel[0] == 1'b1) ? (bus_wdata[0] & ~32'h1) : bus_wdata[0];
    end
  end

  assign bus_rdata[0] = slave_regs[bus_sel[0]];
  assign bus_rdata[1] = BRdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the response handshake.
  task automatic issue(input int d, input bit wr, input logic [0:0] sel,
                       input logic [31:0] wdata, input int stall);
    int          nregs;
    int          rdlat;
    bit          legal;
    int          lat;
    bit          exp_drv;
    logic [31:0] stored;
    exp_t        e;
    exp_t        got;
    nregs = (d == 0) ? 2 : 1;
    rdlat = (d == 0) ? RdLatA : RdLatB;
    legal = int'(sel) < nregs;
    if (!legal) begin
      e.rsp.rdata = '0;
      e.rsp.err   = 1'b1;
      e.lat       = 1;
    end else if (!wr) begin
      e.rsp.rdata = (d == 0) ? shadow[sel] : BRdata;
      e.rsp.err   = 1'b0;
      e.lat       = 2 + rdlat;
    end else begin
      stored = (sel == 1'b1) ? (wdata & ~32'h1) : wdata;
      if (d == 0) shadow[sel] = stored;
      if (Verify) begin
        e.rsp.rdata = (d == 0) ? stored : BRdata;
        e.rsp.err   = (e.rsp.rdata != wdata);
        e.lat       = 3 + rdlat;
      end else begin
        e.rsp.rdata = '0;
        e.rsp.err   = 1'b0;
        e.lat       = 2;
      end
    end
    sb_q.push_back(e);

    check("cmd_ready_idle", cmd_ready[d], 1);
    cmd_valid[d] = 1'b1;
    cmd_write[d] = wr;
    cmd_sel[d]   = sel;
    cmd_wdata[d] = wdata;
    @(posedge clk);
    #1;
    cmd_valid[d] = 1'b0;
    cmd_write[d] = ~wr;
    cmd_sel[d]   = ~sel;
    cmd_wdata[d] = ~wdata;

    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_drv = legal && wr && (k == 1);
      check("bus_rw", bus_rw[d], exp_drv);
      check("bus_oe", bus_oe[d], exp_drv);
      if (exp_drv) check("bus_wdata", bus_wdata[d], wdata);
      if (legal) check("bus_sel", bus_sel[d], sel);
      if (rsp_valid[d]) begin
        lat = k;
        break;
      end
    end
    check("rsp_latency", lat, e.lat);
    got = sb_q.pop_front();
    check("rsp_rdata", rsp_rdata[d], got.rsp.rdata);
    check("rsp_err", rsp_err[d], got.rsp.err);

    for (int s = 0; s < stall; s++) begin
      cmd_valid[d] = 1'b1;
      cmd_write[d] = 1'b0;
      cmd_sel[d]   = 1'b0;
      @(negedge clk);
      check("stall_valid", rsp_valid[d], 1);
      check("stall_rdata", rsp_rdata[d], got.rsp.rdata);
      check("stall_err", rsp_err[d], got.rsp.err);
      check("stall_cmd_ready", cmd_ready[d], 0);
      check("stall_txn", txn_cnt[d], exp_txn[d]);
    end
    cmd_valid[d] = 1'b0;

    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    exp_txn[d]++;
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid[d], 0);
    check("txn_cnt", txn_cnt[d], exp_txn[d]);
    check("cmd_ready_after", cmd_ready[d], 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_write[i] = 1'b0;
      cmd_sel[i]   = 1'b0;
      cmd_wdata[i] = '0;
      rsp_ready[i] = 1'b0;
      shadow[i]    = '0;
      exp_txn[i]   = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready[0], 0);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_bus_oe", bus_oe[0], 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready[0], 1);
    check("post_rst_rsp_rdata", rsp_rdata[0], 0);
    check("post_rst_rsp_err", rsp_err[0], 0);
    check("post_rst_bus_rw", bus_rw[0], 0);
    check("post_rst_bus_sel", bus_sel[0], 0);
    check("post_rst_bus_wdata", bus_wdata[0], 0);
    check("post_rst_txn", txn_cnt[0], 0);
    check("post_rst_cmd_ready_b", cmd_ready[1], 1);

    issue(0, 1'b1, 1'b0, 32'hA5A5_0007, 0);
    issue(0, 1'b0, 1'b0, 32'h0, 0);
    issue(0, 1'b1, 1'b1, 32'h0000_0001, 0);
    issue(0, 1'b0, 1'b1, 32'h0, 0);
    issue(0, 1'b1, 1'b1, 32'h5A5A_F00E, 0);
    issue(0, 1'b0, 1'b1, 32'h0, 5);

    issue(1, 1'b0, 1'b0, 32'h0, 0);
    issue(1, 1'b1, 1'b1, 32'hDEAD_BEEF, 0);
    issue(1, 1'b0, 1'b1, 32'h0, 2);

    // Reset while DUT 0 sits in its read-wait cycle.
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b0;
    cmd_sel[0]   = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    shadow[0]  = '0;
    shadow[1]  = '0;
    exp_txn[0] = '0;
    exp_txn[1] = '0;
    @(negedge clk);
    check("mid_rst_cmd_ready", cmd_ready[0], 1);
    check("mid_rst_rsp_valid", rsp_valid[0], 0);
    check("mid_rst_bus_oe", bus_oe[0], 0);
    check("mid_rst_bus_rw", bus_rw[0], 0);
    check("mid_rst_txn", txn_cnt[0], 0);
    check("mid_rst_txn_b", txn_cnt[1], 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", rsp_valid[0], 0);
    end

    issue(0, 1'b1, 1'b0, 32'h1234_5678, 0);
    issue(0, 1'b0, 1'b0, 32'h0, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
